mem_status_display: RTL

//   Formats memory-controller transactions into six 5-bit digit codes, one per
//   hex_driver instance (HEX5..HEX0). Each accepted read/write/error event is

---
 rtl/mem_status_display.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_status_display.sv
// Formats memory-controller events into six hex_driver digit codes, holding each
// accepted event for HOLD_CYCLES and reverting to dashes after IDLE_TIMEOUT quiet cycles.
module mem_status_display #(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int IDLE_TIMEOUT = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       op_write,
  input  logic       op_err,
  input  logic [7:0] op_addr,
  input  logic [7:0] op_data,
  output logic [4:0] dig5,
  output logic [4:0] dig4,
  output logic [4:0] dig3,
  output logic [4:0] dig2,
  output logic [4:0] dig1,
  output logic [4:0] dig0
);

  localparam int CNT_MAX = (HOLD_CYCLES > IDLE_TIMEOUT) ? HOLD_CYCLES : IDLE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  localparam logic [4:0] D_E    = 5'd14;
  localparam logic [4:0] D_S    = 5'd5;
  localparam logic [4:0] D_R    = 5'd16;
  localparam logic [4:0] D_D    = 5'd17;
  localparam logic [4:0] D_T    = 5'd18;
  localparam logic [4:0] D_UND  = 5'd19;
  localparam logic [4:0] D_DASH = 5'd20;

  typedef enum logic [1:0] {DASH, HOLD, SHOW} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [5:0][4:0]  disp, disp_next;
  logic             in_reset;
  logic             accept;

  function automatic logic [5:0][4:0] event_pattern(input logic       write,
                                                    input logic       err,
                                                    input logic [7:0] addr,
                                                    input logic [7:0] data);
    logic [5:0][4:0] p;
    if (err)
      p = {D_E, D_R, D_R, D_UND, {1'b0, addr[7:4]}, {1'b0, addr[3:0]}};
    else if (write)
      p = {D_S, D_T, {1'b0, addr[7:4]}, {1'b0, addr[3:0]}, {1'b0, data[7:4]}, {1'b0, data[3:0]}};
    else
      p = {D_R, D_D, {1'b0, addr[7:4]}, {1'b0, addr[3:0]}, {1'b0, data[7:4]}, {1'b0, data[3:0]}};
    return p;
  endfunction

  // in_reset keeps op_ready low for the cycles in which reset is being sampled.
  assign op_ready = !in_reset && (state != HOLD);
  assign accept   = op_valid && op_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    disp_next  = disp;
    case (state)
      DASH: begin
        if (accept) begin
          state_next = HOLD;
          cnt_next   = '0;
          disp_next  = event_pattern(op_write, op_err, op_addr, op_data);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = SHOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SHOW: begin
        // A new event wins over a timeout landing on the same edge.
        if (accept) begin
          state_next = HOLD;
          cnt_next   = '0;
          disp_next  = event_pattern(op_write, op_err, op_addr, op_data);
        end else if (IDLE_TIMEOUT != 0) begin
          if (cnt == IDLE_LAST) begin
            state_next = DASH;
            cnt_next   = '0;
            disp_next  = {6{D_DASH}};
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = DASH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DASH;
      cnt      <= '0;
      disp     <= {6{D_DASH}};
      in_reset <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      disp     <= disp_next;
      in_reset <= 1'b0;
    end
  end

  assign dig5 = disp[5];
  assign dig4 = disp[4];
  assign dig3 = disp[3];
  assign dig2 = disp[2];
  assign dig1 = disp[1];
  assign dig0 = disp[0];

endmodule
